wavegen_rate_ctrl: RTL and testbench
====================================

// Module: wavegen_rate_ctrl
// PURPOSE
//  Sequences the 8-bit waveform datapath. Owns the 4-digit frequency setting (keys) and a
//  phase-accumulator rate generator that issues sample_en/phase[7:0] for the 256-point
//  tables. Frequency and wave-type changes are committed only at a phase wrap, so output is
//  glitch-free. No divider IP is used. Sits between key_debounce edge pulses and the wave tables.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock rate; accumulator modulus
//  ACC_W    27           accumulator/step width (CLK_HZ + max step < 2**ACC_W)
//  PH_W     8            phase index width (256 points per period)
//  T_MAX    4            thousands-digit wrap value (other digits wrap at 9)
// PORTS
//  clk100        in   1      system clock
//  clr           in   1      synchronous active-high reset
//  key_t_p       in   1      1-cycle pulse: thousands digit +1 (debounced, edge-detected, clk100 domain)
//  key_h_p       in   1      1-cycle pulse: hundreds digit +1
//  key_d_p       in   1      1-cycle pulse: tens digit +1
//  key_u_p       in   1      1-cycle pulse: units digit +1
//  wave_type_in  in   2      requested waveform (00 tri, 01 square, 10 saw, 11 sine)
//  bcd_disp      out  16     {t,h,d,u} BCD setting for smg_disp (reflects keys immediately)
//  wave_type     out  2      committed waveform select to the output mux
//  phase         out  PH_W   committed table index
//  sample_en     out  1      1-cycle pulse: tables advance/sample this cycle
//  running       out  1      1 = RUN/PEND, 0 = STOP
//  pending       out  1      1 = new freq/type waiting for wrap
// BEHAVIOUR
//  Reset (clr=1 at posedge): digits 0000, freq 0, step 0, acc 0, phase 0, sample_en 0,
//   wave_type 00, state STOP, pending 0, running 0.
//  Digits: each pulse increments its digit; u/d/h wrap 9->0, t wraps T_MAX->0; no carry between
//   digits; simultaneous pulses on several keys are all applied in the same cycle.
//  Latency: key pulse at cycle n -> bcd_disp at n+1; freq_bin = t*1000+h*100+d*10+u registered at
//   n+2; new_step = freq_bin*2**PH_W registered at n+3 (shift, no multiplier beyond x1000/x100/x10).
//  Change detect: new_step != step, or wave_type_in != wave_type -> request.
//  FSM:
//   STOP: acc=0, phase held, sample_en=0. On request: commit step/wave_type the next cycle,
//         phase<=0, acc<=0; -> RUN if new step!=0, else stay STOP (type-only commit).
//   RUN : each cycle sum=acc+step; if sum>=CLK_HZ: acc<=sum-CLK_HZ, sample_en=1, phase<=phase+1
//         (wraps 255->0); else acc<=sum. On request -> PEND.
//   PEND: as RUN. On the sample_en cycle where phase goes 255->0: commit latest new_step and
//         wave_type_in, pending<=0; -> STOP if committed step==0 (phase stays 0), else RUN.
//         Further key pulses in PEND overwrite the pending value; only the latest is committed.
//  Rate: sample_en averages exactly freq*256 per CLK_HZ cycles; no drift (remainder retained).
//  Max step 4999*256=1_279_744 < CLK_HZ, so at most one sample_en per cycle.
//  wave_type_in is sampled through one register before comparison (asynchronous switch input).
//  clr mid-operation: everything returns to reset values on the next edge; no partial commit.
// STRUCTURE
//  Package wavegen_pkg: CLK_HZ default, PH_W, T_MAX, FSM encoding (STOP=2'd0, RUN=2'd1, PEND=2'd2),
//   wave-type codes WT_TRI/WT_SQR/WT_SAW/WT_SIN.
//  Sub-module bcd_digit_cnt (#(MAX)): one-digit wrap counter with clr and inc pulse; 4 instances.
//  Remainder (BCD->bin, step register, accumulator, FSM) stays in this module.
// TESTING (bench CLK_HZ=25_600 for short sims)
//  1. clr, 1 pulse key_u_p -> bcd_disp=0x0001 at n+1; running=1 by n+5; sample_en every 100 cycles,
//     phase 0..255, wrap after 25_600 cycles.
//  2. Running at 1 Hz, set u=3 mid-period -> pending=1; rate unchanged until phase 255->0, then
//     sample_en interval alternates 33/33/34 (3 per 100 cycles), pending=0.
//  3. t key pressed 5x from 0 -> t sequence 1,2,3,4,0; u key 10x -> 1..9,0; press t,h,d,u in same
//     cycle -> bcd_disp=0x1111 next cycle.
//  4. Running, wave_type_in 00->11 at phase 40 -> wave_type stays 00 until phase 255->0 commit,
//     then 11; in STOP the same change commits within 4 cycles of sampling.
//  5. Running, set digits to 0000 -> at next wrap running=0, phase=0, no further sample_en.
//  6. Assert clr during PEND at phase 200 -> next cycle all outputs at reset values, no commit.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared constants, FSM encoding and BCD helper
// for the waveform rate controller.
package wavegen_pkg;
  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int ACC_W_DEF  = 27;
  localparam int PH_W_DEF   = 8;
  localparam int T_MAX_DEF  = 4;
  localparam int FREQ_W     = 13;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [1:0] WT_TRI = 2'b00;
  localparam logic [1:0] WT_SQR = 2'b01;
  localparam logic [1:0] WT_SAW = 2'b10;
  localparam logic [1:0] WT_SIN = 2'b11;

  function automatic logic [FREQ_W-1:0] bcd2bin(
    input logic [15:0] b
  );
    return FREQ_W'(b[15:12]) * FREQ_W'(1000)
         + FREQ_W'(b[11:8])  * FREQ_W'(100)
         + FREQ_W'(b[7:4])   * FREQ_W'(10)
         + FREQ_W'(b[3:0]);
  endfunction
endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit: increments on a pulse,
// wraps MAX -> 0, no carry out.
module bcd_digit_cnt #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_digit
);
  logic [3:0] r_digit;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_digit <= '0;
    end else if (i_inc) begin
      r_digit <= (r_digit == MAX) ? '0
                                  : r_digit + 4'd1;
    end
  end

  assign o_digit = r_digit;
endmodule

// File: rtl/wavegen_rate_ctrl.sv
// Frequency keys, phase-accumulator rate generator and
// wrap-synchronised commit of frequency / wave type.
module wavegen_rate_ctrl
  import wavegen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PH_W   = PH_W_DEF,
  parameter int T_MAX  = T_MAX_DEF
) (
  input  logic            clk100,
  input  logic            clr,
  input  logic            key_t_p,
  input  logic            key_h_p,
  input  logic            key_d_p,
  input  logic            key_u_p,
  input  logic [1:0]      wave_type_in,
  output logic [15:0]     bcd_disp,
  output logic [1:0]      wave_type,
  output logic [PH_W-1:0] phase,
  output logic            sample_en,
  output logic            running,
  output logic            pending
);
  localparam logic [ACC_W:0] LP_MOD =
    (ACC_W+1)'(CLK_HZ);

  logic [3:0]        w_t, w_h, w_d, w_u;
  logic [FREQ_W-1:0] r_freq;
  logic [ACC_W-1:0]  r_new_step, r_step, r_acc;
  logic [1:0]        r_wt_in, r_wt;
  logic [PH_W-1:0]   r_phase;
  logic              r_sen;
  state_e            r_state;

  state_e            w_nx_state;
  logic [ACC_W-1:0]  w_nx_step, w_nx_acc;
  logic [1:0]        w_nx_wt;
  logic [PH_W-1:0]   w_nx_phase;
  logic              w_nx_sen;
  logic [ACC_W:0]    w_sum;
  logic              w_hit, w_req, w_last;

  bcd_digit_cnt #(.MAX(4'(T_MAX))) u_t (
    .i_clk(clk100), .i_clr(clr),
    .i_inc(key_t_p), .o_digit(w_t));
  bcd_digit_cnt #(.MAX(4'd9)) u_h (
    .i_clk(clk100), .i_clr(clr),
    .i_inc(key_h_p), .o_digit(w_h));
  bcd_digit_cnt #(.MAX(4'd9)) u_d (
    .i_clk(clk100), .i_clr(clr),
    .i_inc(key_d_p), .o_digit(w_d));
  bcd_digit_cnt #(.MAX(4'd9)) u_u (
    .i_clk(clk100), .i_clr(clr),
    .i_inc(key_u_p), .o_digit(w_u));

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_step};
  assign w_hit  = (w_sum >= LP_MOD);
  assign w_last = &r_phase;
  assign w_req  = (r_new_step != r_step) ||
                  (r_wt_in != r_wt);

  always_comb begin
    w_nx_state = r_state;
    w_nx_step  = r_step;
    w_nx_wt    = r_wt;
    w_nx_phase = r_phase;
    w_nx_acc   = r_acc;
    w_nx_sen   = 1'b0;
    unique case (r_state)
      ST_STOP: begin
        w_nx_acc = '0;
        if (w_req) begin
          w_nx_step  = r_new_step;
          w_nx_wt    = r_wt_in;
          w_nx_phase = '0;
          if (r_new_step != '0) w_nx_state = ST_RUN;
        end
      end
      ST_RUN, ST_PEND: begin
        if (w_hit) begin
          w_nx_acc   = ACC_W'(w_sum - LP_MOD);
          w_nx_sen   = 1'b1;
          w_nx_phase = r_phase + 1'b1;
        end else begin
          w_nx_acc = ACC_W'(w_sum);
        end
        if (r_state == ST_RUN) begin
          if (w_req) w_nx_state = ST_PEND;
        end else if (w_hit && w_last) begin
          // commit only at the period boundary
          w_nx_step = r_new_step;
          w_nx_wt   = r_wt_in;
          if (r_new_step == '0) begin
            w_nx_state = ST_STOP;
            w_nx_acc   = '0;
          end else begin
            w_nx_state = ST_RUN;
          end
        end
      end
      default: w_nx_state = ST_STOP;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (clr) begin
      r_freq     <= '0;
      r_new_step <= '0;
      r_wt_in    <= WT_TRI;
      r_state    <= ST_STOP;
      r_step     <= '0;
      r_wt       <= WT_TRI;
      r_phase    <= '0;
      r_acc      <= '0;
      r_sen      <= 1'b0;
    end else begin
      r_freq     <= bcd2bin({w_t, w_h, w_d, w_u});
      r_new_step <= ACC_W'(r_freq) << PH_W;
      r_wt_in    <= wave_type_in;
      r_state    <= w_nx_state;
      r_step     <= w_nx_step;
      r_wt       <= w_nx_wt;
      r_phase    <= w_nx_phase;
      r_acc      <= w_nx_acc;
      r_sen      <= w_nx_sen;
    end
  end

  assign bcd_disp  = {w_t, w_h, w_d, w_u};
  assign wave_type = r_wt;
  assign phase     = r_phase;
  assign sample_en = r_sen;
  assign running   = (r_state != ST_STOP);
  assign pending   = (r_state == ST_PEND);
endmodule

// File: tb/tb_wavegen_rate_ctrl.sv
// Scoreboard bench: arithmetic reference model predicts
// every cycle's outputs; a monitor pops and compares.
module tb_wavegen_rate_ctrl;
  localparam int CLK  = 25_600;
  localparam int TMOD = 5;
  localparam int P_PH = 0, P_PEND = 1;
  localparam int P_RUN = 2, P_WT = 3;

  logic        clk100 = 1'b0;
  logic        clr = 1'b1;
  logic        k_t = 1'b0, k_h = 1'b0;
  logic        k_d = 1'b0, k_u = 1'b0;
  logic [1:0]  wti = 2'd0;
  logic [15:0] bcd_disp;
  logic [1:0]  wave_type;
  logic [7:0]  phase;
  logic        sample_en, running, pending;

  always #5 clk100 = ~clk100;

  wavegen_rate_ctrl #(.CLK_HZ(CLK)) dut (
    .clk100(clk100), .clr(clr),
    .key_t_p(k_t), .key_h_p(k_h),
    .key_d_p(k_d), .key_u_p(k_u),
    .wave_type_in(wti), .bcd_disp(bcd_disp),
    .wave_type(wave_type), .phase(phase),
    .sample_en(sample_en), .running(running),
    .pending(pending));

  typedef struct packed {
    logic [15:0] bcd;
    logic [1:0]  wt;
    logic [7:0]  ph;
    logic        sen;
    logic        run;
    logic        pend;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0, n_pass = 0, mon_fail = 0;

  // reference model state
  int         dt, dh, dd, du, rf, cf, ph;
  int         fh[$];
  logic [1:0] wq[$];
  logic [1:0] rw, cwt;
  bit         run, pend, sen, req;
  longint     W, c0, c1;
  obs_t       e_m, e_c, a_c;

  task automatic check(input string nm,
                       input longint act,
                       input longint want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, want);
  endtask

  function automatic bit probe(int sel, int val);
    case (sel)
      P_PH:    return int'(phase) == val;
      P_PEND:  return int'(pending) == val;
      P_RUN:   return int'(running) == val;
      default: return int'(wave_type) == val;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int val,
                           input int bound,
                           input string nm);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk100);
      hit = probe(sel, val);
    end
    n_chk++;
    if (hit) n_pass++;
    else $display("FAIL %s: not reached in %0d cycles",
                  nm, bound);
  endtask

  task automatic next_sample(output int gap);
    gap = -1;
    for (int i = 1; i <= 30000 && gap < 0; i++) begin
      @(negedge clk100);
      if (sample_en) gap = i;
    end
  endtask

  task automatic pulse(input logic t, input logic h,
                       input logic d, input logic u);
    @(negedge clk100);
    {k_t, k_h, k_d, k_u} = {t, h, d, u};
    @(negedge clk100);
    {k_t, k_h, k_d, k_u} = 4'b0;
  endtask

  // model: digits mod N, freq seen after a 2-edge delay,
  // phase = floor(total step units / CLK) mod 256
  initial forever begin
    @(posedge clk100);
    if (clr) begin
      dt = 0; dh = 0; dd = 0; du = 0;
      fh = '{0, 0}; wq = '{2'd0};
      cf = 0; cwt = 2'd0; run = 0; pend = 0;
      W = 0; ph = 0; sen = 0;
    end else begin
      fh.push_back(dt*1000 + dh*100 + dd*10 + du);
      rf = fh.pop_front();
      wq.push_back(wti);
      rw = wq.pop_front();
      dt = (dt + int'(k_t)) % TMOD;
      dh = (dh + int'(k_h)) % 10;
      dd = (dd + int'(k_d)) % 10;
      du = (du + int'(k_u)) % 10;
      sen = 0;
      req = (rf != cf) || (rw != cwt);
      if (!run) begin
        if (req) begin
          cf = rf; cwt = rw; ph = 0; W = 0;
          run = (cf != 0);
        end
      end else begin
        c0 = W / CLK;
        W += longint'(cf) * 256;
        c1 = W / CLK;
        if (c1 != c0) begin
          sen = 1;
          ph = int'(c1 % 256);
        end
        if (pend && sen && ph == 0) begin
          cf = rf; cwt = rw; pend = 0;
          if (cf == 0) begin run = 0; W = 0; end
        end else if (!pend && req) begin
          pend = 1;
        end
      end
    end
    e_m.bcd = {4'(dt), 4'(dh), 4'(dd), 4'(du)};
    e_m.wt = cwt; e_m.ph = 8'(ph);
    e_m.sen = sen; e_m.run = run; e_m.pend = pend;
    exp_q.push_back(e_m);
  end

  initial forever begin
    @(negedge clk100);
    if (exp_q.size() > 0) begin
      e_c = exp_q.pop_front();
      a_c = {bcd_disp, wave_type, phase,
             sample_en, running, pending};
      if (mon_fail < 40) begin
        n_chk++;
        if (a_c === e_c) n_pass++;
        else begin
          mon_fail++;
          $display({"FAIL obs @%0t: got bcd=%h wt=%0d",
            " ph=%0d sen=%b run=%b pend=%b want",
            " bcd=%h wt=%0d ph=%0d sen=%b run=%b",
            " pend=%b"}, $time, a_c.bcd, a_c.wt,
            a_c.ph, a_c.sen, a_c.run, a_c.pend,
            e_c.bcd, e_c.wt, e_c.ph, e_c.sen,
            e_c.run, e_c.pend);
        end
      end
    end
  end

  initial begin
    int g, s, cnt;
    int tseq[5];
    logic kd, ku;
    tseq = '{1, 2, 3, 4, 0};
    repeat (3) @(negedge clk100);
    check("rst_bcd", bcd_disp, 0);
    check("rst_run", running, 0);
    check("rst_ph", phase, 0);
    check("rst_sen", sample_en, 0);
    clr = 1'b0;

    pulse(0, 0, 0, 1);
    check("t1_bcd", bcd_disp, 16'h0001);
    wait_cond(P_RUN, 1, 4, "t1_run_latency");
    next_sample(g); next_sample(g);
    check("t1_gap", g, 100);
    wait_cond(P_PH, 128, 13000, "t1_ph128");

    pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
    check("t2_bcd", bcd_disp, 16'h0003);
    wait_cond(P_PEND, 1, 5, "t2_pend");
    next_sample(g); next_sample(g);
    check("t2_gap_hold", g, 100);
    wait_cond(P_PEND, 0, 14000, "t2_commit");
    check("t2_ph0", phase, 0);
    s = 0;
    for (int i = 0; i < 3; i++) begin
      next_sample(g); s += g;
    end
    check("t2_gap3", s, 100);

    for (int i = 0; i < 5; i++) begin
      pulse(1, 0, 0, 0);
      check("t3_t", bcd_disp[15:12], tseq[i]);
    end
    for (int i = 0; i < 10; i++) begin
      pulse(0, 0, 0, 1);
      check("t3_u", bcd_disp[3:0], (4 + i) % 10);
    end
    pulse(1, 1, 1, 1);
    check("t3_all", bcd_disp, 16'h1114);
    repeat (4) pulse(1, 0, 0, 0);
    repeat (9) pulse(0, 1, 1, 1);
    check("t3_restore", bcd_disp, 16'h0003);
    check("t3_wt_hold", pending, 1);

    repeat (5) pulse(0, 0, 1, 0);
    repeat (7) pulse(0, 0, 0, 1);
    check("f50_bcd", bcd_disp, 16'h0050);
    wait_cond(P_PEND, 0, 9000, "f50_commit");

    wait_cond(P_PH, 40, 600, "t4_ph40");
    wti = 2'b11;
    repeat (20) @(negedge clk100);
    check("t4_wt_hold", wave_type, 0);
    check("t4_pend", pending, 1);
    wait_cond(P_PEND, 0, 600, "t4_commit");
    check("t4_wt", wave_type, 3);

    repeat (5) pulse(0, 0, 1, 0);
    check("t5_bcd", bcd_disp, 0);
    wait_cond(P_RUN, 0, 1200, "t5_stop");
    check("t5_ph0", phase, 0);
    cnt = 0;
    repeat (200) begin
      @(negedge clk100);
      cnt += int'(sample_en);
    end
    check("t5_nosamp", cnt, 0);
    wti = 2'b01;
    wait_cond(P_WT, 1, 4, "t4_stop_commit");

    pulse(0, 0, 1, 0);
    wait_cond(P_RUN, 1, 5, "t6_run");
    pulse(0, 0, 0, 1);
    wait_cond(P_PEND, 1, 5, "t6_pend");
    wait_cond(P_PH, 200, 2600, "t6_ph200");
    clr = 1'b1;
    @(negedge clk100);
    check("t6_bcd", bcd_disp, 0);
    check("t6_run", running, 0);
    check("t6_pend", pending, 0);
    check("t6_ph", phase, 0);
    check("t6_wt", wave_type, 0);
    clr = 1'b0;

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          @(negedge clk100); clr = 1'b1;
          @(negedge clk100); clr = 1'b0;
        end
        1, 2: wti = 2'($urandom_range(0, 3));
        default: begin
          repeat ($urandom_range(1, 3)) begin
            kd = 1'($urandom_range(0, 1));
            ku = 1'($urandom_range(0, 1));
            if (!kd) ku = 1'b1;
            pulse(0, 0, kd, ku);
          end
        end
      endcase
      repeat ($urandom_range(20, 700)) @(negedge clk100);
    end

    repeat (3) @(negedge clk100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
